// File: rtl/lcd_bus_responder.sv
// HD44780-compatible responder for the parallel LCD bus. It decodes writes into an
// 80-byte DDRAM and display-control state, answers status and data reads, models busy
// timing, and exposes the DDRAM through a registered renderer read port.
module lcd_bus_responder #(
    parameter int unsigned BUSY_CYCLES  = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [7:0] lcd_display_readdata,
    input  logic       lcd_enable_writeresponsevalid_n,
    input  logic       lcd_rs_writeresponsevalid_n,
    input  logic       lcd_rw_writeresponsevalid_n,
    output logic [7:0] lcd_data_o,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] cur_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       err,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {StIdle, StClear, StBusy} state_e;

    localparam logic [CNT_W-1:0] BusyLoad  = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] HomeLoad  = CNT_W'(CLEAR_CYCLES - 1);
    // CLEAR already spends 80 cycles wiping cells before the countdown starts.
    localparam logic [CNT_W-1:0] ClearLoad = CNT_W'(CLEAR_CYCLES - 81);

    function automatic logic addr_legal(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Maps a legal DDRAM address onto the dense 0..79 cell index.
    function automatic logic [6:0] addr_idx(input logic [6:0] a);
        return (a >= 7'h40) ? (a - 7'd24) : a;
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    // Pin stage, one-cycle-delayed strobe, registered event and captured bus values
    logic       e_q, rs_q, rw_q, e_qq, evt_q;
    logic [7:0] data_q;
    logic       cap_rs_q, cap_rw_q;
    logic [7:0] cap_data_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       clr_idx_q, clr_idx_d;
    logic [6:0]       cur_addr_q, cur_addr_d;
    logic             id_q, id_d;
    logic             cgram_q, cgram_d;
    logic             disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
    logic             err_q, err_d;
    logic [7:0]       data_o_q, data_o_d;
    logic             oe_q;
    logic [7:0]       rd_data_q;

    logic [7:0] mem_q [80];
    logic       mem_we;
    logic [6:0] mem_widx;
    logic [7:0] mem_wdata;
    logic [7:0] mem_cur;
    logic       busy_w;

    assign busy_w  = (state_q != StIdle);
    assign mem_cur = mem_q[addr_idx(cur_addr_q)];

    // Next-state decode: FSM sequencing, bus event handling and master read data
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_idx_d  = clr_idx_q;
        cur_addr_d = cur_addr_q;
        id_d       = id_q;
        cgram_d    = cgram_q;
        disp_d     = disp_q;
        cursor_d   = cursor_q;
        blink_d    = blink_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_widx   = clr_idx_q;
        mem_wdata  = 8'h20;
        data_o_d   = data_o_q;

        unique case (state_q)
            StClear: begin
                mem_we = 1'b1;
                if (clr_idx_q == 7'd79) begin
                    state_d   = StBusy;
                    cnt_d     = ClearLoad;
                    clr_idx_d = 7'd0;
                end else begin
                    clr_idx_d = clr_idx_q + 7'd1;
                end
            end
            StBusy: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: ;
        endcase

        if (evt_q) begin
            if (!cap_rw_q) begin
                if (busy_w) begin
                    err_d = 1'b1;
                end else if (cap_rs_q) begin
                    if (!cgram_q) begin
                        mem_we     = 1'b1;
                        mem_widx   = addr_idx(cur_addr_q);
                        mem_wdata  = cap_data_q;
                        cur_addr_d = addr_step(cur_addr_q, id_q);
                    end
                    state_d = StBusy;
                    cnt_d   = BusyLoad;
                end else begin
                    state_d = StBusy;
                    cnt_d   = BusyLoad;
                    casez (cap_data_q)
                        8'b1???_????: begin
                            if (addr_legal(cap_data_q[6:0])) begin
                                cur_addr_d = cap_data_q[6:0];
                                cgram_d    = 1'b0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        8'b01??_????: cgram_d = 1'b1;
                        8'b0001_????: begin
                            if (!cap_data_q[3]) begin
                                cur_addr_d = addr_step(cur_addr_q, cap_data_q[2]);
                            end
                        end
                        8'b0000_1???: begin
                            disp_d   = cap_data_q[2];
                            cursor_d = cap_data_q[1];
                            blink_d  = cap_data_q[0];
                        end
                        8'b0000_01??: id_d = cap_data_q[1];
                        8'b0000_001?: begin
                            cur_addr_d = 7'h00;
                            cnt_d      = HomeLoad;
                        end
                        8'b0000_0001: begin
                            cur_addr_d = 7'h00;
                            id_d       = 1'b1;
                            state_d    = StClear;
                            clr_idx_d  = 7'd0;
                        end
                        default: ;
                    endcase
                end
            end else if (cap_rs_q) begin
                if (busy_w) err_d = 1'b1;
                else        cur_addr_d = addr_step(cur_addr_q, id_q);
            end
        end

        // Refreshed every cycle while driving so a status poll sees live busy.
        if (e_q && rw_q) data_o_d = rs_q ? mem_cur : {busy_w, cur_addr_q};
    end

    // Register stage: bus sampling, FSM state and all control/output registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            data_q     <= 8'h00;
            e_qq       <= 1'b0;
            evt_q      <= 1'b0;
            cap_rs_q   <= 1'b0;
            cap_rw_q   <= 1'b0;
            cap_data_q <= 8'h00;
            state_q    <= StClear;
            cnt_q      <= '0;
            clr_idx_q  <= 7'd0;
            cur_addr_q <= 7'h00;
            id_q       <= 1'b1;
            cgram_q    <= 1'b0;
            disp_q     <= 1'b0;
            cursor_q   <= 1'b0;
            blink_q    <= 1'b0;
            err_q      <= 1'b0;
            data_o_q   <= 8'h00;
            oe_q       <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            e_q    <= lcd_enable_writeresponsevalid_n;
            rs_q   <= lcd_rs_writeresponsevalid_n;
            rw_q   <= lcd_rw_writeresponsevalid_n;
            data_q <= lcd_display_readdata;
            e_qq   <= e_q;
            evt_q  <= e_qq & ~e_q;
            if (e_q) begin
                cap_rs_q   <= rs_q;
                cap_rw_q   <= rw_q;
                cap_data_q <= data_q;
            end
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_idx_q  <= clr_idx_d;
            cur_addr_q <= cur_addr_d;
            id_q       <= id_d;
            cgram_q    <= cgram_d;
            disp_q     <= disp_d;
            cursor_q   <= cursor_d;
            blink_q    <= blink_d;
            err_q      <= err_d;
            data_o_q   <= data_o_d;
            oe_q       <= e_q & rw_q;
            rd_data_q  <= addr_legal(rd_addr) ? mem_q[addr_idx(rd_addr)] : 8'h20;
        end
    end

    // DDRAM write port: clear sweep or master data write
    always_ff @(posedge clk_clk) begin
        if (mem_we) mem_q[mem_widx] <= mem_wdata;
    end

    assign lcd_data_o  = data_o_q;
    assign lcd_data_oe = oe_q;
    assign busy        = busy_w;
    assign cur_addr    = cur_addr_q;
    assign disp_on     = disp_q;
    assign cursor_on   = cursor_q;
    assign blink_on    = blink_q;
    assign err         = err_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy timings.
module tb_lcd_bus_responder;

    localparam int unsigned BusyN  = 20;
    localparam int unsigned ClearN = 150;
    localparam int          Limit  = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_pin = 8'h00;
    logic       e_pin = 1'b0, rs_pin = 1'b0, rw_pin = 1'b0;
    logic [7:0] lcd_data_o;
    logic       lcd_data_oe, busy, err, disp_on, cursor_on, blink_on;
    logic [6:0] cur_addr;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_bus_responder #(
        .BUSY_CYCLES (BusyN),
        .CLEAR_CYCLES(ClearN),
        .CNT_W       (17)
    ) dut (
        .clk_clk                        (clk),
        .reset_reset                    (rst),
        .lcd_display_readdata           (d_pin),
        .lcd_enable_writeresponsevalid_n(e_pin),
        .lcd_rs_writeresponsevalid_n    (rs_pin),
        .lcd_rw_writeresponsevalid_n    (rw_pin),
        .lcd_data_o                     (lcd_data_o),
        .lcd_data_oe                    (lcd_data_oe),
        .busy                           (busy),
        .cur_addr                       (cur_addr),
        .disp_on                        (disp_on),
        .cursor_on                      (cursor_on),
        .blink_on                       (blink_on),
        .err                            (err),
        .rd_addr                        (rd_addr),
        .rd_data                        (rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One E pulse; returns just after the edge at which E went low (cycle T).
    task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d,
                             output logic [7:0] rdv, output logic oev);
        @(posedge clk); #1;
        rs_pin = rs; rw_pin = rw; d_pin = d; e_pin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rdv = lcd_data_o;
        oev = lcd_data_oe;
        @(posedge clk); #1;
        e_pin = 1'b0;
    endtask

    // Write, then sample err at T+2/T+3/T+4 and count busy cycles from T+3.
    task automatic do_write(input logic rs, input logic [7:0] d, output logic e_pre,
                            output logic e_at, output logic e_post, output int n);
        logic [7:0] rv;
        logic       ov;
        bus_cycle(rs, 1'b0, d, rv, ov);
        repeat (2) @(posedge clk);
        @(negedge clk);
        e_pre = err;
        @(posedge clk);
        @(negedge clk);
        e_at = err;
        n = busy ? 1 : 0;
        @(negedge clk);
        e_post = err;
        while (busy && n < Limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < Limit) begin
            n++;
            @(negedge clk);
        end
        chk(tag, 32'(n < Limit), 32'd1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < Limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        logic [7:0] rv;
        logic       ov, ep, ea, eo;
        int         n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst data_o", lcd_data_o, 8'h00);
        chk("rst oe", lcd_data_oe, 1'b0);
        chk("rst busy", busy, 1'b1);
        chk("rst cur_addr", cur_addr, 7'h00);
        chk("rst disp", {disp_on, cursor_on, blink_on}, 3'b000);
        chk("rst err", err, 1'b0);
        chk("rst rd_data", rd_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        chk("init busy len", n, ClearN);

        bus_cycle(1'b0, 1'b1, 8'h00, rv, ov);
        chk("status after init", rv, 8'h00);
        chk("status oe", ov, 1'b1);
        for (int a = 0; a < 128; a++) begin
            if (a <= 'h27 || (a >= 'h40 && a <= 'h67)) rd_chk("init cell", 7'(a), 8'h20);
        end
        rd_chk("illegal rd_addr", 7'h28, 8'h20);

        // Set address 0x26, three data writes across the line wrap
        do_write(1'b0, 8'hA6, ep, ea, eo, n);
        chk("set 0x26 busy len", n, BusyN);
        do_write(1'b1, 8'h41, ep, ea, eo, n);
        chk("data busy len", n, BusyN);
        chk("data err", {ep, ea, eo}, 3'b000);
        do_write(1'b1, 8'h42, ep, ea, eo, n);
        do_write(1'b1, 8'h43, ep, ea, eo, n);
        chk("wrap cur_addr", cur_addr, 7'h41);
        rd_chk("cell 0x26", 7'h26, 8'h41);
        rd_chk("cell 0x27", 7'h27, 8'h42);
        rd_chk("cell 0x40", 7'h40, 8'h43);

        // Decrement mode wraps 0x00 -> 0x67
        do_write(1'b0, 8'h04, ep, ea, eo, n);
        do_write(1'b0, 8'h80, ep, ea, eo, n);
        do_write(1'b1, 8'h58, ep, ea, eo, n);
        chk("dec wrap cur_addr", cur_addr, 7'h67);
        rd_chk("cell 0x00", 7'h00, 8'h58);

        // Display control, then a write while busy
        bus_cycle(1'b0, 1'b0, 8'h0F, rv, ov);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("disp ctl", {disp_on, cursor_on, blink_on}, 3'b111);
        bus_cycle(1'b1, 1'b0, 8'h41, rv, ov);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("busy wr err T+2", err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("busy wr err T+3", err, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("busy wr err T+4", err, 1'b0);
        chk("busy wr cur_addr", cur_addr, 7'h67);
        wait_idle("idle after 0x0F");
        rd_chk("cell 0x67 untouched", 7'h67, 8'h20);

        // Illegal DDRAM address
        do_write(1'b0, 8'hA8, ep, ea, eo, n);
        chk("illegal err pulse", {ep, ea, eo}, 3'b010);
        chk("illegal cur_addr", cur_addr, 7'h67);
        chk("illegal busy len", n, BusyN);

        // Clear
        do_write(1'b0, 8'h01, ep, ea, eo, n);
        chk("clear err", ea, 1'b0);
        chk("clear busy len", n, ClearN);
        chk("clear cur_addr", cur_addr, 7'h00);
        rd_chk("clear cell 0x00", 7'h00, 8'h20);
        rd_chk("clear cell 0x40", 7'h40, 8'h20);

        // Data read at 0x40 (clear restores increment mode)
        do_write(1'b0, 8'hC0, ep, ea, eo, n);
        do_write(1'b1, 8'h43, ep, ea, eo, n);
        chk("inc after clear", cur_addr, 7'h41);
        do_write(1'b0, 8'hC0, ep, ea, eo, n);
        bus_cycle(1'b1, 1'b1, 8'h00, rv, ov);
        chk("data read value", rv, 8'h43);
        chk("data read oe", ov, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("oe at T+1", lcd_data_oe, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("oe at T+2", lcd_data_oe, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("read step cur_addr", cur_addr, 7'h41);
        chk("read err", err, 1'b0);

        // Status read served while busy
        bus_cycle(1'b0, 1'b0, 8'h0C, rv, ov);
        bus_cycle(1'b0, 1'b1, 8'h00, rv, ov);
        chk("status while busy", rv, 8'hC1);
        wait_idle("idle after 0x0C");

        // Reset in the middle of CLEAR
        bus_cycle(1'b0, 1'b0, 8'h01, rv, ov);
        repeat (23) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid rst disp", disp_on, 1'b0);
        chk("mid rst busy", busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        chk("restart busy len", n, ClearN);
        rd_chk("restart cell 0x40", 7'h40, 8'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
